// File: rtl/aes_pkg.sv
// Shared definitions for the AES encryption scheduler: FSM states, key-length codes.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    READY  = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic KEY_128 = 1'b0;
  localparam logic KEY_256 = 1'b1;

  // Width of the in-flight block counter (covers the longest round pipeline).
  localparam int IN_FLIGHT_W = 5;

endpackage

// File: rtl/aes_out_fifo.sv
// Ciphertext output buffer: registered storage, first-word-fall-through read.
module aes_out_fifo #(
  parameter int BLOCK_LENGTH = 128,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [BLOCK_LENGTH-1:0]       push_data,
  input  logic                          pop,
  output logic [BLOCK_LENGTH-1:0]       pop_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          empty,
  output logic                          full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [BLOCK_LENGTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    push_ok;
  logic                    pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(FIFO_DEPTH) + 1)'(FIFO_DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Head word is driven straight from storage; forced to zero while empty.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write.
  // NOTE: the data array carries no reset; only pointers and count qualify its contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_enc_sched.sv
// AES encryption scheduler: key-schedule sequencing, credit-based block issue
// into the round pipeline, and in-order ciphertext buffering.
module aes_enc_sched
  import aes_pkg::*;
#(
  parameter int BLOCK_LENGTH = 128,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_LENGTH-1:0] in_block,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic                    key_len,
  output logic                    ks_start,
  output logic                    ks_len,
  input  logic                    ks_done,
  output logic                    pipe_en,
  output logic [BLOCK_LENGTH-1:0] pipe_in,
  input  logic                    pipe_out_valid,
  input  logic [BLOCK_LENGTH-1:0] pipe_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] out_block,
  output logic                    busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = ((CNT_W > IN_FLIGHT_W) ? CNT_W : IN_FLIGHT_W) + 1;

  state_t                 state;
  state_t                 state_next;
  logic                   ks_start_next;
  logic                   load_key;
  logic [IN_FLIGHT_W-1:0] in_flight;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [SUM_W-1:0]       credit_used;
  logic                   accept;
  logic                   pipe_counted;

  // Blocks in the pipeline plus blocks buffered must never exceed the buffer depth.
  assign credit_used  = SUM_W'(in_flight) + SUM_W'(fifo_count);
  assign in_ready     = (state == READY) && !key_valid && !fifo_full &&
                        (credit_used < SUM_W'(FIFO_DEPTH));
  assign accept       = in_valid & in_ready;
  // A pipeline result with nothing outstanding is spurious and dropped.
  assign pipe_counted = pipe_out_valid && (in_flight != '0);
  assign out_valid    = ~fifo_empty;
  assign busy         = (state == KEYEXP) || (state == DRAIN) || (in_flight != '0);

  // Next-state and key-handshake decode.
  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    state_next    = state;
    ks_start_next = 1'b0;
    load_key      = 1'b0;
    key_ready     = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          load_key      = 1'b1;
          ks_start_next = 1'b1;
          state_next    = KEYEXP;
        end
      end
      KEYEXP: begin
        if (ks_done) state_next = READY;
      end
      READY: begin
        key_ready = 1'b1;
        if (key_valid) begin
          load_key   = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Buffered ciphertext may still be waiting; only the pipeline must be empty.
        if (in_flight == '0) begin
          ks_start_next = 1'b1;
          state_next    = KEYEXP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, key-schedule request and latched key length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ks_start <= 1'b0;
      ks_len   <= KEY_128;
    end else begin
      state    <= state_next;
      ks_start <= ks_start_next;
      if (load_key) ks_len <= key_len;
    end
  end

  // Registered round-0 issue and in-flight block accounting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_en   <= 1'b0;
      pipe_in   <= '0;
      in_flight <= '0;
    end else begin
      pipe_en <= accept;
      pipe_in <= accept ? in_block : '0;
      case ({accept, pipe_counted})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  aes_out_fifo #(
    .BLOCK_LENGTH (BLOCK_LENGTH),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_counted),
    .push_data (pipe_out),
    .pop       (out_ready),
    .pop_data  (out_block),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: doc/aes_enc_sched.md
AES_ENC_SCHED -- requirements
Module: aes_enc_sched

Interface
REQ-001 SHALL have parameter BLOCK_LENGTH, default 128, data block width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, output buffer entries; power of two and at least the longest pipeline latency (15).
REQ-003 SHALL have port clk  in  1  clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid / in_ready  in / out  1  plaintext handshake.
REQ-006 SHALL have port in_block  in  BLOCK_LENGTH  plaintext.
REQ-007 SHALL have ports key_valid / key_ready  in / out  1  key-change request handshake.
REQ-008 SHALL have port key_len  in  1  key length with key_valid (0 = AES-128, 1 = AES-256).
REQ-009 SHALL have ports ks_start / ks_len  out / out  1 / 1  key-schedule start pulse and length.
REQ-010 SHALL have port ks_done  in  1  key-schedule complete pulse.
REQ-011 SHALL have ports pipe_en / pipe_in  out / out  1 / BLOCK_LENGTH  round-0 enable and data.
REQ-012 SHALL have ports pipe_out_valid / pipe_out  in / in  1 / BLOCK_LENGTH  final-round enable and ciphertext.
REQ-013 SHALL have ports out_valid / out_ready / out_block  out / in / out  1 / 1 / BLOCK_LENGTH  ciphertext handshake.
REQ-014 SHALL have port busy  out  1  high whenever state is not IDLE or READY, or blocks are in flight.

Function
REQ-015 SHALL implement FSM states IDLE, KEYEXP, READY, DRAIN.
REQ-016 IDLE: key_ready = 1, in_ready = 0; key_valid -> latch key_len, pulse ks_start for 1 cycle, go to KEYEXP.
REQ-017 KEYEXP: in_ready = 0, key_ready = 0; ks_done -> READY.
REQ-018 READY: key_ready = 1; key_valid -> DRAIN with key_len latched; in_ready = 0 from the key_valid cycle onward.
REQ-019 DRAIN: in_ready = 0, key_ready = 0; when in_flight == 0, pulse ks_start and go to KEYEXP; the FIFO is not required to be empty.
REQ-020 in_ready SHALL be 1 only in READY, with key_valid low and (in_flight + fifo_count) < FIFO_DEPTH.
REQ-021 Each accepted input (in_valid & in_ready) SHALL drive pipe_en = 1 and pipe_in = in_block on the next cycle (registered).
REQ-022 On all other cycles pipe_en = 0 and pipe_in = 0.
REQ-023 in_flight counter (5 bits): +1 on accept, -1 on pipe_out_valid, unchanged when both occur in the same cycle.
REQ-024 A pipe_out_valid pulse with in_flight == 0 SHALL be ignored: no FIFO write and no counter change.
REQ-025 Each counted pipe_out_valid SHALL write pipe_out to the FIFO tail; the credit rule guarantees the FIFO never overflows.
REQ-026 out_valid = (fifo_count != 0); out_block = FIFO head, registered-storage first-word-fall-through.
REQ-027 A written entry SHALL become visible on out_valid no earlier than the cycle after the write.
REQ-028 Pop on out_valid & out_ready; simultaneous push and pop leaves fifo_count unchanged.
REQ-029 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 Output order SHALL equal input acceptance order.
REQ-031 ks_len SHALL hold the latched key_len from ks_start until the next key change.

Reset
REQ-032 On rst low, all of the following SHALL be set asynchronously: state = IDLE; in_flight, pointers and fifo_count = 0; pipe_en, pipe_in, ks_start, ks_len, out_valid, out_block, in_ready = 0; key_ready = 1 (IDLE value); busy = 0.
REQ-033 A reset mid-operation SHALL discard all in-flight and buffered blocks.
REQ-034 The round pipeline is reset by the same rst, so no stale pipe_out_valid arrives afterwards.

Structure
REQ-035 State encoding and key-length constants (KEY_128 = 0, KEY_256 = 1) SHALL be defined in shared package aes_pkg.
REQ-036 The output buffer SHALL be a sub-module aes_out_fifo (parameters BLOCK_LENGTH, FIFO_DEPTH; outputs count, empty, full).
REQ-037 The FSM and counters SHALL live in aes_enc_sched.

Verification
REQ-038 Key load: reset, key_valid with key_len = 0, ks_done 3 cycles later -> one ks_start pulse, ks_len = 0, in_ready = 1 one cycle after ks_done.
REQ-039 Streaming: 20 back-to-back blocks, model pipeline latency 11, out_ready = 1 -> 20 outputs in order, out_valid first 13 cycles after the first accept.
REQ-040 Backpressure: out_ready = 0, continuous in_valid -> exactly 16 accepts, then in_ready = 0; one pop -> exactly one further accept.
REQ-041 Key change mid-stream: key_valid with key_len = 1 while 5 blocks in flight -> ks_start only after the 5th pipe_out_valid; all 5 ciphertexts delivered; ks_len = 1.
REQ-042 Simultaneous events: accept and pipe_out_valid in the same cycle, plus push and pop in the same cycle -> in_flight and fifo_count unchanged; pointer wrap checked after 40 blocks.
REQ-043 Reset mid-stream: rst low with 8 in flight and 4 buffered -> out_valid = 0, in_ready = 0, state IDLE, busy = 0 immediately.
